// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Holds the fetch PC, registers the fetched word with its PC and PC+4, and
// applies stalls, redirects, flushes and the decoder-requested halt.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap on misaligned
// redirect targets (sticky flag plus HALT) instead of forcing alignment.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_f_i,
    input  logic        flush_d_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        pause_d_i,
    input  logic        resume_i,
    output logic [31:0] instr_d_o,
    output logic [31:0] pc_d_o,
    output logic [31:0] pcplus4_d_o,
    output logic        valid_d_o,
    output logic        halted_o,
    output logic        misaligned_o
);

    typedef enum logic {StRun, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pcplus4_q, id_pcplus4_d;
    logic        valid_q, valid_d;

    logic [31:0] target_pc;
    logic [31:0] fetch_pc_plus4;
    logic        mis_trap;
    logic        mis_d;
    logic        pause_take;
    logic        enter_halt;
    logic        halt_hold;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic mis_q;

    // Target is used as-is; a misaligned one raises the trap.
    assign target_pc = redirect_pc_i;
    assign mis_trap  = redirect_i & (|redirect_pc_i[1:0]);
    assign mis_d     = mis_q | mis_trap;

    // Sticky misaligned flag, cleared only by reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign misaligned_o = mis_q;
`else
    logic unused_pc_lsb;

    // Low target bits are dropped so fetch stays word aligned.
    assign target_pc     = {redirect_pc_i[31:2], 2'b00};
    assign mis_trap      = 1'b0;
    assign mis_d         = 1'b0;
    assign unused_pc_lsb = ^redirect_pc_i[1:0];
    assign misaligned_o  = 1'b0;
`endif

    assign fetch_pc_plus4 = fetch_pc_q + 32'd4;

    // A pause only counts for a real word that is not being squashed this cycle.
    assign pause_take = (state_q == StRun) & pause_d_i & valid_q & ~redirect_i & ~flush_d_i;
    assign enter_halt = (state_q == StRun) & (pause_take | mis_trap);
    assign halt_hold  = (state_q == StHalt) | enter_halt;

    // Run/halt next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (enter_halt) begin
                    state_d = StHalt;
                end
            end
            StHalt: begin
                if (resume_i && !mis_d) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // Fetch PC selection: redirect, then halt hold, then stall hold, else +4.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_i) begin
            fetch_pc_d = target_pc;
        end else if (halt_hold || stall_f_i) begin
            fetch_pc_d = fetch_pc_q;
        end else begin
            fetch_pc_d = fetch_pc_plus4;
        end
    end

    // IF/ID next value: bubble, hold, or capture the fetched word.
    always_comb begin
        instr_d      = instr_q;
        id_pc_d      = id_pc_q;
        id_pcplus4_d = id_pcplus4_q;
        valid_d      = valid_q;
        if (redirect_i || flush_d_i || halt_hold) begin
            // Bubble keeps the previous PC fields.
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!stall_f_i) begin
            instr_d      = imem_rdata_i;
            id_pc_d      = fetch_pc_q;
            id_pcplus4_d = fetch_pc_plus4;
            valid_d      = 1'b1;
        end
    end

    // State, PC and IF/ID registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= StRun;
            fetch_pc_q   <= RESET_PC;
            instr_q      <= NOP_INSTR;
            id_pc_q      <= 32'd0;
            id_pcplus4_q <= 32'd0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            instr_q      <= instr_d;
            id_pc_q      <= id_pc_d;
            id_pcplus4_q <= id_pcplus4_d;
            valid_q      <= valid_d;
        end
    end

    assign imem_addr_o = fetch_pc_q;
    assign instr_d_o   = instr_q;
    assign pc_d_o      = id_pc_q;
    assign pcplus4_d_o = id_pcplus4_q;
    assign valid_d_o   = valid_q;
    assign halted_o    = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed stimulus, a behavioural model checked at
// every falling edge, and hand-computed literal checks at key points.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall_f = 1'b0;
    logic        flush_d = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        pause_d = 1'b0;
    logic        resume = 1'b0;
    logic [31:0] instr_d, pc_d, pcplus4_d;
    logic        valid_d, halted, misaligned;

    int total = 0;
    int bad = 0;

    fetch_stage dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (imem_rdata),
        .stall_f_i     (stall_f),
        .flush_d_i     (flush_d),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .pause_d_i     (pause_d),
        .resume_i      (resume),
        .instr_d_o     (instr_d),
        .pc_d_o        (pc_d),
        .pcplus4_d_o   (pcplus4_d),
        .valid_d_o     (valid_d),
        .halted_o      (halted),
        .misaligned_o  (misaligned)
    );

    always #5 clk = ~clk;

    // Instruction memory: each word is its address xor a fixed key.
    assign imem_rdata = imem_addr ^ KEY;

    // Behavioural model of the architectural outputs.
    logic [31:0] m_pc, m_instr, m_pcd, m_pcp4;
    logic        m_valid, m_halt, m_mis;

    always @(posedge clk or posedge reset) begin
        logic [31:0] tgt;
        logic        trap, take, going, squash;
        if (reset) begin
            m_pc = RST_PC; m_instr = NOP; m_pcd = 0; m_pcp4 = 0;
            m_valid = 0; m_halt = 0; m_mis = 0;
        end else begin
            tgt = redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap = redirect && (tgt[1:0] != 2'b00);
`else
            tgt = tgt & 32'hFFFF_FFFC;
            trap = 1'b0;
`endif
            take   = !m_halt && pause_d && m_valid && !redirect && !flush_d;
            going  = !m_halt && (take || trap);
            squash = redirect || flush_d || m_halt || going;
            if (squash) begin
                m_instr = NOP; m_valid = 0;
            end else if (!stall_f) begin
                m_instr = m_pc ^ KEY; m_pcd = m_pc; m_pcp4 = m_pc + 32'd4; m_valid = 1;
            end
            if (redirect) m_pc = tgt;
            else if (!(m_halt || going || stall_f)) m_pc = m_pc + 32'd4;
            m_mis = m_mis || trap;
            if (m_halt) m_halt = !(resume && !m_mis);
            else m_halt = going;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: all outputs against the model on every falling edge.
    always @(negedge clk) begin
        chk("m_imem_addr", imem_addr, m_pc);
        chk("m_instr_d", instr_d, m_instr);
        chk("m_pc_d", pc_d, m_pcd);
        chk("m_pcplus4_d", pcplus4_d, m_pcp4);
        chk("m_valid_d", {31'd0, valid_d}, {31'd0, m_valid});
        chk("m_halted", {31'd0, halted}, {31'd0, m_halt});
        chk("m_misaligned", {31'd0, misaligned}, {31'd0, m_mis});
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #1 reset = 1'b1;
        tick();
        chk("rst_imem", imem_addr, 32'h0);
        chk("rst_instr", instr_d, 32'h13);
        chk("rst_valid", {31'd0, valid_d}, 32'd0);
        chk("rst_pc_d", pc_d, 32'h0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("run_instr0", instr_d, 32'hA5A5_0000);
        chk("run_pc0", pc_d, 32'h0);
        chk("run_valid0", {31'd0, valid_d}, 32'd1);
        tick();
        chk("run_instr4", instr_d, 32'hA5A5_0004);
        chk("run_imem8", imem_addr, 32'h8);
        // Stall three cycles at PC 8.
        stall_f = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_imem", imem_addr, 32'h8);
            chk("stall_pc_d", pc_d, 32'h4);
        end
        stall_f = 1'b0;
        tick();
        chk("post_stall_instr", instr_d, 32'hA5A5_0008);
        chk("post_stall_imem", imem_addr, 32'hC);
        // Redirect wins over stall and flush.
        redirect = 1'b1; redirect_pc = 32'h100; stall_f = 1'b1; flush_d = 1'b1;
        tick();
        redirect = 1'b0; stall_f = 1'b0; flush_d = 1'b0;
        chk("redir_imem", imem_addr, 32'h100);
        chk("redir_bubble", instr_d, 32'h13);
        chk("redir_keep_pc", pc_d, 32'h8);
        tick();
        chk("redir_pc_d", pc_d, 32'h100);
        chk("redir_instr", instr_d, 32'hA5A5_0100);
        chk("redir_pcp4", pcplus4_d, 32'h104);
        // Pause word at 0x20.
        redirect = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect = 1'b0;
        tick();
        chk("pause_word_pc", pc_d, 32'h20);
        pause_d = 1'b1;
        tick();
        pause_d = 1'b0;
        chk("halt_set", {31'd0, halted}, 32'd1);
        chk("halt_imem", imem_addr, 32'h24);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_hold_imem", imem_addr, 32'h24);
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume_clear", {31'd0, halted}, 32'd0);
        tick();
        chk("resume_pc_d", pc_d, 32'h24);
        // Pause killed by a same-cycle redirect.
        pause_d = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        chk("killed_pause", {31'd0, halted}, 32'd0);
        chk("killed_imem", imem_addr, 32'h40);
        // Pause with valid_d=0 is ignored.
        tick();
        pause_d = 1'b0;
        chk("bubble_pause", {31'd0, halted}, 32'd0);
        chk("bubble_pause_pc", pc_d, 32'h40);
        // Resume in RUN is ignored.
        resume = 1'b1;
        tick();
        chk("resume_run", {31'd0, halted}, 32'd0);
        // Pause and resume together: pause wins.
        pause_d = 1'b1;
        tick();
        pause_d = 1'b0; resume = 1'b0;
        chk("pause_resume", {31'd0, halted}, 32'd1);
        chk("pause_resume_imem", imem_addr, 32'h48);
        // Redirect while halted loads PC but stays halted.
        redirect = 1'b1; redirect_pc = 32'h80;
        tick();
        redirect = 1'b0;
        chk("halt_redir_imem", imem_addr, 32'h80);
        tick();
        chk("halt_redir_stay", {31'd0, halted}, 32'd1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        tick();
        chk("halt_redir_pc_d", pc_d, 32'h80);
        // Plain flush.
        flush_d = 1'b1;
        tick();
        flush_d = 1'b0;
        chk("flush_valid", {31'd0, valid_d}, 32'd0);
        chk("flush_imem", imem_addr, 32'h88);
        // PC+4 wraparound.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        tick();
        chk("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
        chk("wrap_pcp4", pcplus4_d, 32'h0);
        chk("wrap_imem", imem_addr, 32'h0);
        chk("wrap_instr", instr_d, 32'h5A5A_FFFC);
        // Misaligned redirect.
        redirect = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_imem", imem_addr, 32'h102);
        chk("mis_flag", {31'd0, misaligned}, 32'd1);
        chk("mis_halt", {31'd0, halted}, 32'd1);
`else
        chk("mis_imem", imem_addr, 32'h100);
        chk("mis_flag", {31'd0, misaligned}, 32'd0);
`endif
        resume = 1'b1;
        tick();
        resume = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_resume", {31'd0, halted}, 32'd1);
`else
        chk("mis_resume", {31'd0, halted}, 32'd0);
`endif
        // Asynchronous reset mid-cycle.
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_imem", imem_addr, 32'h0);
        chk("async_instr", instr_d, 32'h13);
        chk("async_halted", {31'd0, halted}, 32'd0);
        chk("async_mis", {31'd0, misaligned}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("after_rst_instr", instr_d, 32'hA5A5_0000);
        tick();
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register that feeds the main decoder. It holds the PC, drives the instruction-memory address, and registers the fetched word, its PC and PC+4 for the decode stage. It also applies hazard stalls, branch/jump redirects and flushes, and implements the halt requested by the decoder's `pause` output.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013 (`addi x0,x0,0`): bubble word placed in IF/ID.
- `clk` in 1: clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `imem_addr` out 32: current fetch PC. It is the PC register itself.
- `imem_rdata` in 32: instruction at `imem_addr`, combinational (same-cycle) read.
- `stall_f` in 1: hazard unit holds the PC and IF/ID.
- `flush_d` in 1: replace IF/ID contents with a bubble.
- `redirect` in 1: taken branch or jump resolved in EX.
- `redirect_pc` in 32: target address when `redirect`=1.
- `pause_d` in 1: decoder `pause` for the word currently in IF/ID.
- `resume` in 1: leave HALT.
- `instr_d` out 32: registered instruction to the decoder.
- `pc_d` out 32: PC of `instr_d`.
- `pcplus4_d` out 32: `pc_d`+4.
- `valid_d` out 1: IF/ID holds a real instruction.
- `halted` out 1: stage is in HALT.
- `misaligned` out 1: sticky misaligned-target flag.

## Operation
- **States**
  - RUN: normal fetch.
  - HALT: PC frozen and IF/ID held at bubble.
- **Transitions**
  - RUN→HALT when `pause_d`&`valid_d`&!`redirect`&!`flush_d`.
  - HALT→RUN when `resume`=1.
  - HALT is also entered on a misaligned redirect when `FETCH_MISALIGN_TRAP_EN` is defined.
- **PC next**, priority high to low:
  1. `redirect` → `redirect_pc`.
  2. HALT, or entering HALT → hold.
  3. `stall_f` → hold.
  4. Otherwise → PC+4.
- **IF/ID next**, priority high to low:
  1. `redirect`|`flush_d`|HALT|entering HALT → bubble.
  2. `stall_f` → hold.
  3. Otherwise → {`imem_rdata`, PC, PC+4, valid=1}.
  - Bubble value: `instr_d`=`NOP_INSTR`, `valid_d`=0. `pc_d`/`pcplus4_d` keep their previous values.
- **Arithmetic:** PC+4 is a 32-bit add; it wraps 32'hFFFF_FFFC → 32'h0000_0000 silently.
- **Pause handling**
  - A `pause_d` with `valid_d`=0 is ignored.
  - A pause killed by a same-cycle redirect or flush is ignored (it is on the wrong path).
  - When HALT is entered, the PC holds `pc_d`+4 of the pause word. The word fetched behind it is discarded.
  - After `resume`, fetch restarts at that address.
- **Redirect while HALT:** the PC loads `redirect_pc`, but the stage stays in HALT until `resume`.
- **`resume` in RUN:** ignored.
- **`resume` and pause entry in the same cycle:** pause entry wins; stay in HALT.
- **Reset values:**
  - `imem_addr`=`RESET_PC`, `instr_d`=`NOP_INSTR`.
  - `pc_d`=0, `pcplus4_d`=0, `valid_d`=0.
  - `halted`=0, `misaligned`=0, state RUN.
- **Reset mid-operation:** clears everything immediately (asynchronous), including HALT and `misaligned`.

## Timing
- Latency:
  - The word at `imem_addr`=P appears on `instr_d` one cycle later, with `pc_d`=P.
  - Sustained throughput is one instruction per cycle.
- Redirect at edge N:
  - `imem_addr`=`redirect_pc` after N.
  - IF/ID holds a bubble after N.
  - The target word reaches `instr_d` after N+1.
- `halted` is registered: it rises the cycle after the pause condition and falls the cycle after `resume`.
- `stall_f` for k cycles holds `imem_addr` and all IF/ID outputs unchanged for k cycles.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 loads the PC unmodified.
  - It sets `misaligned`=1 (sticky until reset) and enters HALT.
  - `resume` does not leave HALT while `misaligned`=1.
- `FETCH_MISALIGN_TRAP_EN` not defined:
  - `redirect_pc[1:0]` is forced to 2'b00.
  - `misaligned` is tied to 0.

## Test plan
- Reset then run 4 cycles, imem returning addr^32'hA5A5_0000 → `instr_d` sequence for PCs 0, 4, 8. First cycle after reset `valid_d`=0, `instr_d`=32'h13.
- `stall_f`=1 for 3 cycles at PC 8 → `imem_addr`=8 and `pc_d`=4 held for 3 cycles. Fetch resumes at 12.
- `redirect`=1, `redirect_pc`=32'h100, with `stall_f`=1 and `flush_d`=1 in the same cycle → `imem_addr`=32'h100 and a bubble next cycle. `pc_d`=32'h100 one cycle later.
- Pause word at PC 32'h20, so `pause_d`=1 with `valid_d`=1 → `halted`=1 and `imem_addr`=32'h24 held indefinitely. `resume` → `pc_d`=32'h24 two cycles later.
- Pause word with a same-cycle `redirect` to 32'h40 → no halt. Fetch continues at 32'h40.
- With the macro: `redirect_pc`=32'h102 → `misaligned`=1 and `halted`=1, and `resume` is ignored. Without the macro: `imem_addr`=32'h100 and `misaligned`=0.
